// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and defaults for the RAM access controller: FSM state
// encodings, requester IDs and default address/data widths.
package ram_access_ctrl_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } state_t;

  typedef enum logic {
    REQ_ID_A = 1'b0,
    REQ_ID_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Bundle of requester handshakes and RAM array lines. The slave modport is the
// controller; the master modport is the environment (requesters plus the array).
interface ram_access_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);

  logic          REQ_A;
  logic          REQ_B;
  logic          WE_A;
  logic          WE_B;
  logic [AW-1:0] ADDR_A;
  logic [AW-1:0] ADDR_B;
  logic [DW-1:0] WDATA_A;
  logic [DW-1:0] WDATA_B;
  logic          ACK_A;
  logic          ACK_B;
  logic [DW-1:0] RDATA_A;
  logic [DW-1:0] RDATA_B;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_CS;
  logic          MEM_R;
  logic          MEM_W;
  logic [DW-1:0] MEM_D;
  logic [DW-1:0] MEM_Q;
  logic          BUSY;

  modport slave (
    input  REQ_A, REQ_B, WE_A, WE_B, ADDR_A, ADDR_B, WDATA_A, WDATA_B, MEM_Q,
    output ACK_A, ACK_B, RDATA_A, RDATA_B, MEM_ADDR, MEM_CS, MEM_R, MEM_W,
           MEM_D, BUSY
  );

  modport master (
    output REQ_A, REQ_B, WE_A, WE_B, ADDR_A, ADDR_B, WDATA_A, WDATA_B, MEM_Q,
    input  ACK_A, ACK_B, RDATA_A, RDATA_B, MEM_ADDR, MEM_CS, MEM_R, MEM_W,
           MEM_D, BUSY
  );

endinterface

// File: rtl/ram_access_ctrl_arb2.sv
// Two-way request arbiter. RAM_ACCESS_CTRL_RR_EN selects round-robin with a
// one-bit pointer; otherwise fixed priority with A over B and no state.
module arb2
  import ram_access_ctrl_pkg::*;
(
  input  logic    CLK,
  input  logic    RST_N,
  input  logic    req_a,
  input  logic    req_b,
  input  logic    en,
  output req_id_t winner
);

`ifdef RAM_ACCESS_CTRL_RR_EN
  logic    prio_b_r;
  req_id_t winner_s;

  // Pick the requester, breaking ties with the pointer.
  always_comb begin
    winner_s = REQ_ID_A;
    if (req_a && req_b) begin
      winner_s = prio_b_r ? REQ_ID_B : REQ_ID_A;
    end else if (req_b) begin
      winner_s = REQ_ID_B;
    end else begin
      winner_s = REQ_ID_A;
    end
  end

  // The requester just granted drops to lowest priority.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prio_b_r <= 1'b0;
    end else if (en && (req_a || req_b)) begin
      prio_b_r <= (winner_s == REQ_ID_A);
    end else begin
      prio_b_r <= prio_b_r;
    end
  end

  assign winner = winner_s;
`else
  logic unused_ok;

  // Fixed priority: B only wins when A is not requesting.
  always_comb begin
    winner = REQ_ID_A;
    if (req_a) begin
      winner = REQ_ID_A;
    end else if (req_b) begin
      winner = REQ_ID_B;
    end else begin
      winner = REQ_ID_A;
    end
  end

  assign unused_ok = ^{CLK, RST_N, en};
`endif

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencing/arbitration controller between two requesters and a word RAM.
// Optional round-robin arbitration via RAM_ACCESS_CTRL_RR_EN (see arb2).
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
)(
  input  logic              CLK,
  input  logic              RST_N,
  ram_access_ctrl_if.slave  bus
);

  state_t        state_r;
  req_id_t       txn_id_r;
  req_id_t       winner_s;
  logic          txn_we_r;
  logic [AW-1:0] txn_addr_r;
  logic [DW-1:0] txn_wdata_r;
  logic [DW-1:0] rdata_a_r;
  logic [DW-1:0] rdata_b_r;
  logic          mem_cs_r;
  logic          mem_r_r;
  logic          mem_w_r;
  logic          ack_a_r;
  logic          ack_b_r;
  logic          busy_r;
  logic          win_we_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_wdata_s;
  logic          arb_en_s;
  logic          any_req_s;

  assign arb_en_s  = (state_r == IDLE);
  assign any_req_s = bus.REQ_A | bus.REQ_B;

  arb2 u_arb (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .req_a  (bus.REQ_A),
    .req_b  (bus.REQ_B),
    .en     (arb_en_s),
    .winner (winner_s)
  );

  // Route the winning requester's command fields toward the transaction registers.
  always_comb begin
    win_we_s    = bus.WE_A;
    win_addr_s  = bus.ADDR_A;
    win_wdata_s = bus.WDATA_A;
    if (winner_s == REQ_ID_B) begin
      win_we_s    = bus.WE_B;
      win_addr_s  = bus.ADDR_B;
      win_wdata_s = bus.WDATA_B;
    end else begin
      win_we_s    = bus.WE_A;
      win_addr_s  = bus.ADDR_A;
      win_wdata_s = bus.WDATA_A;
    end
  end

  // Transaction FSM; every array control and handshake output is a register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      txn_id_r    <= REQ_ID_A;
      txn_we_r    <= 1'b0;
      txn_addr_r  <= {AW{1'b0}};
      txn_wdata_r <= {DW{1'b0}};
      rdata_a_r   <= {DW{1'b0}};
      rdata_b_r   <= {DW{1'b0}};
      mem_cs_r    <= 1'b0;
      mem_r_r     <= 1'b0;
      mem_w_r     <= 1'b0;
      ack_a_r     <= 1'b0;
      ack_b_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            txn_id_r    <= winner_s;
            txn_we_r    <= win_we_s;
            txn_addr_r  <= win_addr_s;
            txn_wdata_r <= win_wdata_s;
            mem_cs_r    <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= SETUP;
          end else begin
            state_r     <= IDLE;
          end
        end
        SETUP: begin
          mem_r_r <= ~txn_we_r;
          mem_w_r <= txn_we_r;
          state_r <= ACCESS;
        end
        ACCESS: begin
          // MEM_Q is only defined here, so it is captured on leaving ACCESS.
          if (!txn_we_r && (txn_id_r == REQ_ID_A)) begin
            rdata_a_r <= bus.MEM_Q;
          end else if (!txn_we_r) begin
            rdata_b_r <= bus.MEM_Q;
          end else begin
            rdata_a_r <= rdata_a_r;
          end
          mem_cs_r <= 1'b0;
          mem_r_r  <= 1'b0;
          mem_w_r  <= 1'b0;
          ack_a_r  <= (txn_id_r == REQ_ID_A);
          ack_b_r  <= (txn_id_r == REQ_ID_B);
          state_r  <= DONE;
        end
        DONE: begin
          ack_a_r <= 1'b0;
          ack_b_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_cs_r <= 1'b0;
          mem_r_r  <= 1'b0;
          mem_w_r  <= 1'b0;
          ack_a_r  <= 1'b0;
          ack_b_r  <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.MEM_ADDR = txn_addr_r;
  assign bus.MEM_D    = txn_wdata_r;
  assign bus.MEM_CS   = mem_cs_r;
  assign bus.MEM_R    = mem_r_r;
  assign bus.MEM_W    = mem_w_r;
  assign bus.ACK_A    = ack_a_r;
  assign bus.ACK_B    = ack_b_r;
  assign bus.RDATA_A  = rdata_a_r;
  assign bus.RDATA_B  = rdata_b_r;
  assign bus.BUSY     = busy_r;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: behavioural RAM array, a word-level
// reference memory, directed scenarios plus randomized transactions.
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] ram      [NW];
  logic [DW-1:0] ref_mem  [NW];
  bit            ref_known[NW];
  logic [DW-1:0] exp_rdata[2];
  bit            rd_known [2];

  always #5 clk = ~clk;

  ram_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  ram_access_ctrl #(.AW(AW), .DW(DW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  // Storage array: writes land on the clock edge ending a write strobe.
  always @(posedge clk) begin
    if (bus.MEM_CS && bus.MEM_W) ram[bus.MEM_ADDR] <= bus.MEM_D;
  end
  assign bus.MEM_Q = (bus.MEM_CS && bus.MEM_R) ? ram[bus.MEM_ADDR] : {DW{1'bx}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input bit id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 1'b0) begin
      bus.REQ_A = 1'b1; bus.WE_A = we; bus.ADDR_A = a; bus.WDATA_A = d;
    end else begin
      bus.REQ_B = 1'b1; bus.WE_B = we; bus.ADDR_B = a; bus.WDATA_B = d;
    end
  endtask

  task automatic drop_req(input bit id);
    if (id == 1'b0) bus.REQ_A = 1'b0;
    else            bus.REQ_B = 1'b0;
  endtask

  task automatic chk_rdata();
    if (rd_known[0]) chk("rdata_a", 32'(bus.RDATA_A), 32'(exp_rdata[0]));
    if (rd_known[1]) chk("rdata_b", 32'(bus.RDATA_B), 32'(exp_rdata[1]));
  endtask

  task automatic note_read(input bit id, input logic [AW-1:0] a);
    rd_known[id] = ref_known[a];
    if (ref_known[a]) exp_rdata[id] = ref_mem[a];
  endtask

  task automatic do_txn(input bit id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat = 0;
    int cs_n = 0;
    int r_n = 0;
    int w_n = 0;
    bit got = 1'b0;
    @(negedge clk);
    drive_req(id, we, a, d);
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.MEM_CS) cs_n++;
      if (bus.MEM_R) r_n++;
      if (bus.MEM_W) begin
        w_n++;
        chk("w_addr", 32'(bus.MEM_ADDR), 32'(a));
        chk("w_data", 32'(bus.MEM_D), 32'(d));
      end
      if (bus.MEM_R) chk("r_addr", 32'(bus.MEM_ADDR), 32'(a));
      chk("rw_excl", 32'(bus.MEM_R & bus.MEM_W), 32'd0);
      if (lat == 1) chk("busy", 32'(bus.BUSY), 32'd1);
      got = (id == 1'b0) ? bus.ACK_A : bus.ACK_B;
    end
    drop_req(id);
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'd3);
    chk("other_ack", 32'((id == 1'b0) ? bus.ACK_B : bus.ACK_A), 32'd0);
    chk("cs_cycles", 32'(cs_n), 32'd2);
    chk("r_cycles", 32'(r_n), we ? 32'd0 : 32'd1);
    chk("w_cycles", 32'(w_n), we ? 32'd1 : 32'd0);
    if (we) begin
      ref_mem[a]   = d;
      ref_known[a] = 1'b1;
    end else begin
      note_read(id, a);
    end
    chk_rdata();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit    ids [$];
    int    cyc [$];
    bit    exp_ids [$];
    int    t;
    int    busy_n;
    logic [DW-1:0] rv;

    bus.REQ_A = 1'b0; bus.REQ_B = 1'b0; bus.WE_A = 1'b0; bus.WE_B = 1'b0;
    bus.ADDR_A = '0; bus.ADDR_B = '0; bus.WDATA_A = '0; bus.WDATA_B = '0;
    for (int i = 0; i < NW; i++) ref_known[i] = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    rd_known[0] = 1'b1; rd_known[1] = 1'b1;

    // Reset state
    #12;
    chk("rst_outputs", 32'({bus.ACK_A, bus.ACK_B, bus.MEM_CS, bus.MEM_R, bus.MEM_W, bus.BUSY}), 32'd0);
    chk("rst_data", 32'({bus.RDATA_A, bus.RDATA_B, bus.MEM_D, bus.MEM_ADDR}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every address, 0 through 15, alternating requesters
    for (int i = 0; i < NW; i++) do_txn(i[0], 1'b1, AW'(i), DW'($urandom));

    // Single write/read by A
    do_txn(1'b0, 1'b1, 4'd5, 8'h3C);
    do_txn(1'b0, 1'b0, 4'd5, 8'h00);
    chk("rd_5", 32'(bus.RDATA_A), 32'h3C);

    // Cross-requester coherence at the top address
    do_txn(1'b0, 1'b0, 4'd1, 8'h00);
    do_txn(1'b1, 1'b0, 4'd2, 8'h00);
    do_txn(1'b1, 1'b1, 4'd15, 8'hFF);
    do_txn(1'b0, 1'b0, 4'd15, 8'h00);
    chk("rd_15", 32'(bus.RDATA_A), 32'hFF);

    // Reset during the ACCESS cycle of a write
    @(negedge clk);
    drive_req(1'b0, 1'b1, 4'd3, 8'hA5);
    @(negedge clk);
    @(negedge clk);
    chk("mw_before_rst", 32'(bus.MEM_W), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({bus.ACK_A, bus.ACK_B, bus.MEM_CS, bus.MEM_R, bus.MEM_W, bus.BUSY}), 32'd0);
    chk("mid_rst_data", 32'({bus.RDATA_A, bus.RDATA_B, bus.MEM_D, bus.MEM_ADDR}), 32'd0);
    drop_req(1'b0);
    ref_known[3] = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 1'b0, 4'd3, 8'h00);

    // Both requesters held; reset first so arbitration starts favouring A
    reset_pulse();
    @(negedge clk);
    drive_req(1'b0, 1'b0, 4'd2, 8'h00);
    drive_req(1'b1, 1'b0, 4'd9, 8'h00);
    t = 0;
    while (t < 40 && bus.REQ_B) begin
      @(negedge clk);
      t++;
      if (bus.ACK_A || bus.ACK_B) begin
        ids.push_back(bus.ACK_B);
        cyc.push_back(t);
        note_read(bus.ACK_B, bus.ACK_B ? 4'd9 : 4'd2);
        chk_rdata();
`ifdef RAM_ACCESS_CTRL_RR_EN
        if (ids.size() == 4) begin drop_req(1'b0); drop_req(1'b1); end
`else
        if (ids.size() == 4) drop_req(1'b0);
        if (bus.ACK_B) drop_req(1'b1);
`endif
      end
    end
    drop_req(1'b0);
    drop_req(1'b1);
`ifdef RAM_ACCESS_CTRL_RR_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    chk("grant_count", 32'(ids.size()), 32'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < ids.size(); i++) begin
      chk($sformatf("grant_%0d", i), 32'(ids[i]), 32'(exp_ids[i]));
      chk($sformatf("ack_time_%0d", i), 32'(cyc[i]), 32'(3 + 4 * i));
    end

    // Withdrawal: B drops its request one cycle after the grant
    @(negedge clk);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 4'd7, 8'h00);
    @(negedge clk);
    chk("wd_busy", 32'(bus.BUSY), 32'd1);
    drop_req(1'b1);
    @(negedge clk);
    chk("wd_no_early_ack", 32'(bus.ACK_B), 32'd0);
    @(negedge clk);
    chk("wd_ack_b", 32'(bus.ACK_B), 32'd1);
    note_read(1'b1, 4'd7);
    chk_rdata();
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.BUSY || bus.ACK_B) busy_n++;
    end
    chk("wd_no_rerun", 32'(busy_n), 32'd0);

    // Randomized transactions against the reference memory
    for (int i = 0; i < 24; i++) begin
      rv = DW'($urandom);
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, NW - 1)), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Sequencing and arbitration controller for a word-organised RAM built from binary storage cells. It accepts read/write requests from two independent requesters (A and B), grants one at a time, and drives the array's chip-select, read-enable, write-enable, address and data lines with the setup/access phasing the cells require. Read data is captured in a register, so requesters never see the array's undriven (X) output. The block sits between the array and its two clients, for example a CPU port and a loader/DMA port.

## Interface
- `AW`, default 4: address width; the array holds 2^AW words.
- `DW`, default 8: data word width.

- `CLK`  in  1  system clock, rising-edge active.
- `RST_N`  in  1  asynchronous, active-low reset.
- `REQ_A` / `REQ_B`  in  1  request from requester A / B; held high until that requester's ACK.
- `WE_A` / `WE_B`  in  1  1 = write, 0 = read; stable while REQ is high.
- `ADDR_A` / `ADDR_B`  in  AW  word address.
- `WDATA_A` / `WDATA_B`  in  DW  write data.
- `ACK_A` / `ACK_B`  out  1  one-cycle completion pulse.
- `RDATA_A` / `RDATA_B`  out  DW  registered read data; valid from the ACK cycle until the next ACK to the same requester.
- `MEM_ADDR`  out  AW  array address, decoded externally to row chip-selects.
- `MEM_CS`  out  1  array chip select.
- `MEM_R`  out  1  array read enable.
- `MEM_W`  out  1  array write enable.
- `MEM_D`  out  DW  array write data.
- `MEM_Q`  in  DW  array read data; valid only while MEM_CS and MEM_R are both high.
- `BUSY`  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS and DONE.
- **IDLE**
  - With no request pending, the FSM stays in IDLE.
  - If any REQ is high, the arbiter picks a winner and latches its WE, ADDR and WDATA into the transaction registers. The FSM then moves to SETUP.
- **SETUP** (one cycle)
  - MEM_CS=1, and MEM_ADDR/MEM_D are driven from the transaction registers.
  - MEM_R=0, MEM_W=0.
  - Next state: ACCESS.
- **ACCESS** (one cycle)
  - MEM_CS=1, with MEM_W=1 for a write or MEM_R=1 for a read. MEM_ADDR and MEM_D are held.
  - For a read, MEM_Q is captured into the winner's RDATA register at the end of this cycle.
  - Next state: DONE.
- **DONE** (one cycle)
  - All MEM_* controls are 0, and ACK of the winner pulses high.
  - Next state: IDLE.
- **Arbitration**
  - If only one REQ is high, that requester wins.
  - If both are high, the winner depends on the configuration (see Configuration).
- **Request withdrawal**
  - A REQ dropped after its grant does not abort the transaction; the ACK is still issued.
  - A REQ dropped before its grant is simply never served.
- **Boundaries**
  - Every address from 0 to 2^AW−1 is legal; there is no wrap-around or checking.
  - A write by one requester followed by a read of the same address by the other returns the new data.
- **Reset**
  - RST_N low at any time, including mid-transaction, forces the FSM to IDLE.
  - Every output resets to 0: ACK_*, RDATA_*, MEM_*, BUSY.
  - The round-robin pointer resets to favour A.
  - An interrupted write leaves that array word undefined.

## Timing
- The request is sampled in IDLE at edge N, giving SETUP in cycle N+1, ACCESS in N+2 and ACK in N+3. Latency is fixed at 3 cycles from grant to ACK.
- Throughput is at most one transaction per 4 cycles. A REQ still high in the cycle after ACK is treated as a new request.
- MEM_ADDR and MEM_D are stable for the whole of SETUP and ACCESS, i.e. one cycle of setup before MEM_W or MEM_R rises.
- MEM_R and MEM_W are never high in the same cycle, and never high outside ACCESS.

## Configuration
- `RAM_ACCESS_CTRL_RR_EN` defined: round-robin arbitration.
  - The requester just served has lowest priority at the next arbitration.
  - With both REQs held continuously, grants alternate A, B, A, B.
- Macro undefined: fixed priority, A over B.
  - B is served only when REQ_A is low in the IDLE cycle.
  - No pointer register exists.

## Structure
- The shared package holds:
  - the state encodings (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, DONE=2'b11);
  - the requester IDs (REQ_ID_A=1'b0, REQ_ID_B=1'b1);
  - the default AW and DW.
- The arbiter is one sub-module, `arb2`. Its inputs are the two requests, an enable (IDLE), CLK and RST_N. Its output is the winner ID. It contains the round-robin pointer when `RAM_ACCESS_CTRL_RR_EN` is defined.
- The FSM, transaction registers and RDATA registers live in the top module.

## Test plan
- **Reset mid-write:** A writes 8'hA5 to address 3, and RST_N is pulsed low during ACCESS → all outputs are 0 immediately and the FSM is in IDLE. A following read of address 3 completes with ACK after 3 cycles.
- **Single write/read:** A writes 8'h3C to address 5, then A reads address 5.
  - MEM_W is high exactly one cycle, with MEM_ADDR=5.
  - ACK_A arrives 3 cycles after each grant.
  - RDATA_A is 8'h3C.
- **Simultaneous requests, RR build:** REQ_A and REQ_B are held high for 4 transactions → grant order A, B, A, B, with ACKs 4 cycles apart.
- **Simultaneous requests, fixed-priority build:** same stimulus → A is served on every grant while REQ_A stays high; B is served only after REQ_A drops.
- **Cross-requester coherence:** B writes 8'hFF to address 15 (top address), then A reads address 15 → RDATA_A is 8'hFF, and RDATA_B is unchanged.
- **Withdrawal:** REQ_B drops one cycle after its grant → ACK_B still pulses at grant+3, and no further B transaction starts.
